// File: rtl/uart_tx_fifo_drain.sv
// UART TX: pops one byte at a time from the FIFO read port and serialises it LSB-first onto o_tx.
// Latency: rd_en at T -> start bit at T+2; no new read is issued until the current frame's stop bits finish.
module uart_tx_fifo_drain #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_fifo_rd_en,
    input  logic [DATA_BITS-1:0] i_fifo_rd_data,
    input  logic                 i_fifo_rd_valid,
    input  logic                 i_fifo_empty,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state;
    logic [BAUD_W-1:0]    r_baud;
    logic [2:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_rd_en;
    logic                 r_done;
    logic                 w_baud_end;

    assign w_baud_end   = (r_baud == BAUD_LAST);
    assign o_fifo_rd_en = r_rd_en;
    assign o_tx         = r_tx;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    r_bit  <= '0;
                    // A read issued on the way into IDLE is consumed here, so only one is ever outstanding.
                    if (r_rd_en) begin
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                    end else begin
                        r_rd_en <= !i_fifo_empty;
                    end
                end
                S_FETCH: begin
                    r_baud <= '0;
                    if (i_fifo_rd_valid) begin
                        r_shift <= i_fifo_rd_data;
                        r_par   <= (PARITY == 2) ? ~^i_fifo_rd_data : ^i_fifo_rd_data;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_rd_en <= !i_fifo_empty;
                    end
                end
                S_START: begin
                    r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
                    if (w_baud_end) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
                    if (w_baud_end) begin
                        if (r_bit == DATA_LAST) begin
                            r_bit <= '0;
                            if (PARITY != 0) begin
                                r_tx    <= r_par;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
                    if (w_baud_end) begin
                        r_tx    <= 1'b1;
                        r_bit   <= '0;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
                    // Raised one cycle early so the registered pulse lands on the final stop cycle.
                    if (r_bit == STOP_LAST && r_baud == BAUD_PRE) begin
                        r_done <= 1'b1;
                    end
                    if (w_baud_end) begin
                        if (r_bit == STOP_LAST) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_bit   <= '0;
                            r_rd_en <= !i_fifo_empty;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
